weight_sram_fetcher: RTL and testbench

// Initiator side of sp_ram_intf for the EPU weight store: accepts block read/write commands
// (base word address, length), drives cs/oe/W_req/addr/W_data to the 2-bank 18b weight SRAM
// and returns read words on a valid/ready stream. Sits between the EPU sequencer/DMA and the

---
 rtl/weight_sram_fetcher_pkg.sv | 16 +
 rtl/weight_sram_fetcher_if.sv | 39 +++
 rtl/weight_sram_fetcher_fifo.sv | 54 +++++
 rtl/weight_sram_fetcher.sv | 155 +++++++++++++++
 tb/tb_weight_sram_fetcher.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_sram_fetcher_pkg.sv
// Shared types and sizes for the EPU weight-store fetcher.
// The range check and the bus padding both rely on these sizes.
package weight_fetch_pkg;
  localparam int WEIGHT_MEM_WORDS = 32768;
  localparam int WEIGHT_ADDR_W    = 17;
  localparam int WEIGHT_DATA_W    = 18;
  localparam int WEIGHT_BUS_W     = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/weight_sram_fetcher_if.sv
// Command, write-data, read-return and SRAM pins of the weight fetcher.
// master = fetcher side, slave = sequencer/DMA plus SRAM side.
interface weight_sram_fetcher_if #(
  parameter int ADDR_W = 17
);
  import weight_fetch_pkg::*;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [ADDR_W-1:0]        cmd_len;
  logic [WEIGHT_DATA_W-1:0] wr_data;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [WEIGHT_BUS_W-1:0]  rd_data;
  logic                     rd_valid;
  logic                     rd_ready;
  logic                     done;
  logic                     err;
  logic                     mem_cs;
  logic                     mem_oe;
  logic                     mem_W_req;
  logic [WEIGHT_BUS_W-1:0]  mem_addr;
  logic [WEIGHT_BUS_W-1:0]  mem_W_data;
  logic [WEIGHT_BUS_W-1:0]  mem_R_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_R_data,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
           mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_R_data,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
           mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data
  );
endinterface

// File: rtl/weight_sram_fetcher_fifo.sv
// Small read-return FIFO; a push into a full FIFO is accepted only when
// the head is popped in the same cycle.
module weight_fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wptr_d  = push_ok ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop_ok ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_ok) mem_q[wptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/weight_sram_fetcher.sv
// Initiator for the 2-bank weight SRAM: block reads into a valid/ready
// stream (hiding the 1-cycle read latency) and block writes from a stream.
module weight_sram_fetcher
  import weight_fetch_pkg::*;
#(
  parameter int MEM_WORDS  = WEIGHT_MEM_WORDS,
  parameter int ADDR_W     = WEIGHT_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  weight_sram_fetcher_if.master bus
);
  localparam int                CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   MEM_END = (ADDR_W + 1)'(MEM_WORDS);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              inflight_q, inflight_d;
  logic              err_q, err_d;

  logic              accept, range_bad, issue, wr_hs, pop, credit_ok;
  logic              last_issue, last_write, drained;
  logic [ADDR_W:0]   end_addr;
  logic [ADDR_W-1:0] issued_inc;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              fifo_empty;
  logic [31:0]       fifo_head;

  weight_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.mem_R_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign end_addr   = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign range_bad  = end_addr > MEM_END;
  assign accept     = (state_q == IDLE) && bus.cmd_valid;
  assign pop        = !fifo_empty && bus.rd_ready;
  assign issued_inc = issued_q + ADDR_W'(1);

  // Credit: a new issue lands in the FIFO two edges later, so count what
  // the FIFO will hold after this cycle's push/pop and keep one slot free.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign credit_ok  = occupancy < DEPTH_C;

  assign issue      = (state_q == READ) && (issued_q < len_q) && credit_ok;
  assign last_issue = issue && (issued_inc == len_q);
  assign wr_hs      = (state_q == WRITE) && bus.wr_valid;
  assign last_write = wr_hs && (issued_inc == len_q);
  // Leave DRAIN as the final word is taken, so done follows it directly.
  assign drained    = !inflight_q && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !range_bad)
                 state_d = (bus.cmd_len == '0) ? DONE : (bus.cmd_write ? WRITE : READ);
      READ:    if (last_issue) state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      WRITE:   if (last_write) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = (state_q == IDLE);
    bus.wr_ready   = (state_q == WRITE);
    bus.done       = (state_q == DONE);
    bus.err        = err_q;
    bus.rd_valid   = !fifo_empty;
    bus.rd_data    = fifo_head;
    bus.mem_cs     = 1'b0;
    bus.mem_oe     = 1'b0;
    bus.mem_W_req  = 1'b1;
    bus.mem_addr   = '0;
    bus.mem_W_data = '0;
    unique case (state_q)
      READ, DRAIN: begin
        // OE stays up so the bank selected by the held address drives R_data.
        bus.mem_oe   = 1'b1;
        bus.mem_addr = 32'(last_addr_q);
        if (issue) begin
          bus.mem_cs   = 1'b1;
          bus.mem_addr = 32'(cur_q);
        end
      end
      WRITE: begin
        if (wr_hs) begin
          bus.mem_cs     = 1'b1;
          bus.mem_W_req  = 1'b0;
          bus.mem_addr   = 32'(cur_q);
          bus.mem_W_data = 32'(bus.wr_data);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_d       = cur_q;
    len_d       = len_q;
    issued_d    = issued_q;
    last_addr_d = last_addr_q;
    inflight_d  = issue;
    err_d       = accept && range_bad;
    if (accept && !range_bad) begin
      cur_d       = bus.cmd_addr;
      len_d       = bus.cmd_len;
      issued_d    = '0;
      last_addr_d = bus.cmd_addr;
    end else if (issue || wr_hs) begin
      cur_d       = cur_q + ADDR_W'(1);
      issued_d    = issued_inc;
      last_addr_d = cur_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q       <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_weight_sram_fetcher.sv
// Directed bench for weight_sram_fetcher with a behavioural 1-cycle SRAM
// preloaded with mem[a] = a.
module tb_weight_sram_fetcher;
  import weight_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_sram_fetcher_if #(.ADDR_W(17)) bus ();

  weight_sram_fetcher u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model
  logic [17:0] sram [WEIGHT_MEM_WORDS];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < WEIGHT_MEM_WORDS; i++) sram[i] <= 18'(i);
      loaded <= 1'b1;
    end else begin
      if (bus.mem_cs && !bus.mem_W_req) sram[bus.mem_addr[14:0]] <= bus.mem_W_data[17:0];
      if (bus.mem_cs && bus.mem_W_req)
        bus.mem_R_data <= {{14{sram[bus.mem_addr[14:0]][17]}}, sram[bus.mem_addr[14:0]]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge
  logic        clr_mon = 1'b0;
  int          rd_q[$];
  int          hs_cyc[$];
  int          first_rv, done_cnt, done_cyc, err_cnt, err_cyc;
  int          cs_cnt, wreq_lo, wreq_bad, stall_bad, fifo_max;
  logic        prev_stall;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (clr_mon) begin
      rd_q.delete();
      hs_cyc.delete();
      first_rv  <= -1;
      done_cnt  <= 0;
      done_cyc  <= -1;
      err_cnt   <= 0;
      err_cyc   <= -1;
      cs_cnt    <= 0;
      wreq_lo   <= 0;
      wreq_bad  <= 0;
      stall_bad <= 0;
      fifo_max  <= 0;
      prev_stall <= 1'b0;
    end else if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.rd_valid && first_rv < 0) first_rv <= cyc;
      if (bus.rd_valid && bus.rd_ready) begin
        rd_q.push_back(int'(bus.rd_data));
        hs_cyc.push_back(cyc);
      end
      if (prev_stall && (!bus.rd_valid || bus.rd_data != prev_data)) stall_bad <= stall_bad + 1;
      prev_stall <= bus.rd_valid && !bus.rd_ready;
      prev_data  <= bus.rd_data;
      if (bus.done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (bus.err)  begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
      if (bus.mem_cs) cs_cnt <= cs_cnt + 1;
      if (!bus.mem_W_req) begin
        wreq_lo <= wreq_lo + 1;
        if (!(bus.mem_cs && bus.wr_valid && bus.wr_ready)) wreq_bad <= wreq_bad + 1;
      end
      if (int'(u_dut.fifo_count) > fifo_max) fifo_max <= int'(u_dut.fifo_count);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_rd(input int i);
    return (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic mon_clear();
    clr_mon = 1'b1;
    @(negedge clk);
    #1 clr_mon = 1'b0;
  endtask

  task automatic send_cmd(input logic w, input int addr, input int len, output int acc);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = 17'(addr);
    bus.cmd_len   = 17'(len);
    @(posedge clk); #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (toggle) bus.rd_ready = ((k / 2) % 2 == 0);
      @(posedge clk); #1;
      k++;
    end
    bus.rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"},  32'(bus.cmd_ready), 32'd1);
    chk({tag, " wr_ready"},   32'(bus.wr_ready),  32'd0);
    chk({tag, " rd_valid"},   32'(bus.rd_valid),  32'd0);
    chk({tag, " done"},       32'(bus.done),      32'd0);
    chk({tag, " err"},        32'(bus.err),       32'd0);
    chk({tag, " mem_cs"},     32'(bus.mem_cs),    32'd0);
    chk({tag, " mem_oe"},     32'(bus.mem_oe),    32'd0);
    chk({tag, " mem_W_req"},  32'(bus.mem_W_req), 32'd1);
    chk({tag, " mem_addr"},   bus.mem_addr,       32'd0);
    chk({tag, " mem_W_data"}, bus.mem_W_data,     32'd0);
  endtask

  logic [17:0] wd [3] = '{18'h3FFFF, 18'h00001, 18'h20000};
  logic [31:0] wexp [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFE_0000};
  int          gaps [3] = '{0, 1, 2};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Read across the bank boundary
    mon_clear();
    send_cmd(1'b0, 32'h3FFE, 4, acc);
    wait_done("rd_bank", 50, 1'b0);
    chk("rd_bank count", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rd_bank word%0d", i), get_rd(i), 32'h3FFE + 32'(i));
    chk("rd_bank first_latency", 32'(first_rv - acc), 32'd2);
    if (hs_cyc.size() == 4) begin
      chk("rd_bank back_to_back", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
      chk("rd_bank done_after_last", 32'(done_cyc - hs_cyc[3]), 32'd1);
    end

    // Write with gaps, then read back
    mon_clear();
    send_cmd(1'b1, 32'h10, 3, acc);
    for (int i = 0; i < 3; i++) begin
      repeat (gaps[i]) begin
        bus.wr_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = wd[i];
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    wait_done("wr", 50, 1'b0);
    chk("wr wreq_low_cycles", 32'(wreq_lo), 32'd3);
    chk("wr wreq_outside_hs", 32'(wreq_bad), 32'd0);
    chk("wr cs_cycles", 32'(cs_cnt), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("wr sram%0d", i), 32'(sram[16 + i]), 32'(wd[i]));
    mon_clear();
    send_cmd(1'b0, 32'h10, 3, acc);
    wait_done("rdback", 50, 1'b0);
    for (int i = 0; i < 3; i++) chk($sformatf("rdback word%0d", i), get_rd(i), wexp[i]);

    // Backpressure: rd_ready 1,1,0,0,...
    mon_clear();
    send_cmd(1'b0, 32'h100, 8, acc);
    wait_done("bp", 100, 1'b1);
    chk("bp count", 32'(rd_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("bp word%0d", i), get_rd(i), 32'h100 + 32'(i));
    chk("bp stall_stable", 32'(stall_bad), 32'd0);
    chk("bp fifo_le_2", 32'(fifo_max <= 2), 32'd1);

    // Range: end beyond MEM_WORDS rejected, exactly at end accepted
    mon_clear();
    send_cmd(1'b0, 32'h7FFF, 2, acc);
    repeat (3) @(posedge clk);
    #1;
    chk("range err_pulses", 32'(err_cnt), 32'd1);
    chk("range err_cycle", 32'(err_cyc - acc), 32'd0);
    chk("range no_cs", 32'(cs_cnt), 32'd0);
    chk("range no_done", 32'(done_cnt), 32'd0);
    chk("range cmd_ready", 32'(bus.cmd_ready), 32'd1);
    mon_clear();
    send_cmd(1'b0, 32'h7FFF, 1, acc);
    wait_done("edge", 50, 1'b0);
    chk("edge word", get_rd(0), 32'h7FFF);
    chk("edge no_err", 32'(err_cnt), 32'd0);

    // Zero length
    mon_clear();
    send_cmd(1'b0, 32'h20, 0, acc);
    wait_done("len0", 20, 1'b0);
    chk("len0 done_cycle", 32'(done_cyc - acc), 32'd0);
    chk("len0 no_cs", 32'(cs_cnt), 32'd0);
    chk("len0 no_rd", 32'(rd_q.size()), 32'd0);

    // Reset mid-read with two words outstanding
    mon_clear();
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 32'h200, 8, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rd_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst rd_valid_after", 32'(bus.rd_valid), 32'd0);
    chk("midrst no_done", 32'(done_cnt), 32'd0);
    mon_clear();
    send_cmd(1'b0, 32'h300, 2, acc);
    wait_done("post", 50, 1'b0);
    chk("post count", 32'(rd_q.size()), 32'd2);
    chk("post word0", get_rd(0), 32'h300);
    chk("post word1", get_rd(1), 32'h301);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
